serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor computing D = X − Y over W cycles, LSB first, with one full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the team's combinational adder cells. It trades latency for area and sits beside the adder blocks as the arithmetic unit for narrow datapaths.

---
 rtl/serial_sub_pkg.sv | 30 +++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
//------------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and helpers for the bit-serial subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; the shift counter runs 0..W-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
//------------------------------------------------------------------------------
// full_subtractor
// One-bit full-subtractor cell: A - Bi - Bin.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module full_subtractor (
    input  logic A,
    input  logic Bi,
    input  logic Bin,
    output logic Dout,
    output logic Bout
);

    assign Dout = A ^ Bi ^ Bin;
    assign Bout = (~A & Bi) | (~(A ^ Bi) & Bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned D = X - Y, LSB first over W cycles, with final borrow.
// Optional signed-overflow output V when SERIAL_SUB_OVF_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         READY,
    output logic         DONE,
    output logic [W-1:0] D,
    output logic         B
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int            CW     = clog2(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    state_t          state_q;
    logic [W-1:0]    xr_q;
    logic [W-1:0]    yr_q;
    logic [W-1:0]    d_q;
    logic [W-1:0]    d_d;
    logic [CW-1:0]   count_q;
    logic            borrow_q;
    logic            b_q;
    logic            ready_q;
    logic            done_q;
    logic            w_dout;
    logic            w_bout;

    full_subtractor u_cell (
        .A    (xr_q[0]),
        .Bi   (yr_q[0]),
        .Bin  (borrow_q),
        .Dout (w_dout),
        .Bout (w_bout)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place after W shifts.
    assign d_d = {w_dout, d_q[W-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic xs_q;
    logic ys_q;
    logic v_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            xs_q <= 1'b0;
            ys_q <= 1'b0;
            v_q  <= 1'b0;
        end else if (state_q == IDLE && START) begin
            xs_q <= X[W-1];
            ys_q <= Y[W-1];
        end else if (state_q == SHIFT && count_q == C_LAST) begin
            // w_dout here is the final MSB of the difference.
            v_q <= (xs_q ^ ys_q) & (w_dout ^ xs_q);
        end
    end

    assign V = v_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            yr_q     <= '0;
            d_q      <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            b_q      <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        xr_q     <= X;
                        yr_q     <= Y;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    xr_q     <= {1'b0, xr_q[W-1:1]};
                    yr_q     <= {1'b0, yr_q[W-1:1]};
                    d_q      <= d_d;
                    borrow_q <= w_bout;
                    count_q  <= count_q + 1'b1;
                    if (count_q == C_LAST) begin
                        b_q     <= w_bout;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign READY = ready_q;
    assign DONE  = done_q;
    assign D     = d_q;
    assign B     = b_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor at W=8.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         READY;
    logic         DONE;
    logic [W-1:0] D;
    logic         B;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    serial_subtractor #(.W(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .X     (X),
        .Y     (Y),
        .READY (READY),
        .DONE  (DONE),
        .D     (D),
        .B     (B)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic         b;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         v;
    } exp_t;

    vec_t tbl [10];
    exp_t sb [$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.d = v.d;
        e.b = v.b;
        e.v = v.v;
        sb.push_back(e);
    endtask

    // Drive one operation from an IDLE point away from the edge; check its timeline.
    task automatic run_op(input vec_t v);
        X = v.x;
        Y = v.y;
        START = 1'b1;
        push_exp(v);
        @(posedge CLK);
        #1;
        START = 1'b0;
        X = W'($urandom);
        Y = W'($urandom);
        chk("ready_low_after_accept", READY, 1'b0);
        for (int k = 1; k <= W; k++) begin
            @(posedge CLK);
            #1;
            X = W'($urandom);
            Y = W'($urandom);
            chk("done_timing", DONE, (k == W));
        end
        @(posedge CLK);
        #1;
        chk("ready_back", READY, 1'b1);
        chk("done_dropped", DONE, 1'b0);
    endtask

    // Scoreboard: every DONE pulse consumes one expected result.
    always @(negedge CLK) begin
        if (DONE) begin
            chk("done_single_cycle", prev_done, 1'b0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DONE=1 required no pulse");
            end else begin
                mon_e = sb.pop_front();
                chk("diff", D, mon_e.d);
                chk("borrow", B, mon_e.b);
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow", V, mon_e.v);
`endif
            end
        end
        prev_done = DONE;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
        tbl[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[6] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        tbl[9] = '{8'h37, 8'h37, 8'h00, 1'b0, 1'b0};

        // Reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", READY, 1'b1);
        chk("rst_done", DONE, 1'b0);
        chk("rst_d", D, 8'h00);
        chk("rst_b", B, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_v", V, 1'b0);
`endif
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i]);
        end

        // START held high: accepts on edges 0, 10, 20; operands change mid-shift.
        X = tbl[0].x;
        Y = tbl[0].y;
        START = 1'b1;
        push_exp(tbl[0]);
        for (int e = 0; e < 30; e++) begin
            @(posedge CLK);
            #1;
            chk("held_done", DONE, (e == 8 || e == 18 || e == 28));
            chk("held_ready", READY, (e == 9 || e == 19 || e == 29));
            if (e == 9 || e == 19) begin
                X = tbl[(e == 9) ? 1 : 2].x;
                Y = tbl[(e == 9) ? 1 : 2].y;
                push_exp(tbl[(e == 9) ? 1 : 2]);
            end else begin
                X = W'($urandom);
                Y = W'($urandom);
            end
            if (e == 29) START = 1'b0;
        end

        // Abort mid-shift: RST on shift edge 4, then a fresh operation.
        X = tbl[0].x;
        Y = tbl[0].y;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("abort_ready", READY, 1'b1);
        chk("abort_done", DONE, 1'b0);
        chk("abort_d", D, 8'h00);
        chk("abort_b", B, 1'b0);
        run_op(tbl[1]);

        // RST wins over START on the same edge.
        X = tbl[2].x;
        Y = tbl[2].y;
        START = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        START = 1'b0;
        chk("rst_prio_ready", READY, 1'b1);
        repeat (W + 2) @(posedge CLK);
        #1;
        chk("rst_prio_idle", READY, 1'b1);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
